rgb_fade_sequencer: RTL and testbench

- Sequences the three PWM level inputs of the rgb_mixer datapath.
- In manual mode it passes the encoder-derived levels straight through.
- In auto mode it fades the levels through a 4-entry colour palette at a programmable rate, dwelling on each entry.
- Encoder activity temporarily overrides auto mode. Sits between the encoder counters/LA config bits and the three PWM generators inside the user project wrapper.

---
 rtl/rgb_fade_sequencer_pkg.sv | 46 ++++
 rtl/rgb_fade_sequencer_if.sv | 24 ++
 rtl/rgb_tick_gen.sv | 27 ++
 rtl/rgb_fade_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared types and helpers for the RGB fade sequencer.
// State encoding, default palette masks and the per-channel step function.
package rgb_seq_pkg;

   typedef enum logic [1:0] {
      MANUAL  = 2'd0,
      FADE    = 2'd1,
      DWELL   = 2'd2,
      HOLDOFF = 2'd3
   } seq_state_t;

   // Channel masks {R,G,B}; a set bit means full scale.
   localparam logic [2:0] DEF_MASK0 = 3'b100;
   localparam logic [2:0] DEF_MASK1 = 3'b010;
   localparam logic [2:0] DEF_MASK2 = 3'b001;
   localparam logic [2:0] DEF_MASK3 = 3'b111;

   // Wide enough for any supported channel width.
   localparam int STEP_W = 16;

   function automatic logic [2:0] default_mask(input int unsigned i);
      logic [2:0] m;
      case (i % 4)
         0: m = DEF_MASK0;
         1: m = DEF_MASK1;
         2: m = DEF_MASK2;
         default: m = DEF_MASK3;
      endcase
      return m;
   endfunction

   // One unit toward tgt; never passes it.
   function automatic logic [STEP_W-1:0] step_toward(
      input logic [STEP_W-1:0] cur,
      input logic [STEP_W-1:0] tgt
   );
      logic [STEP_W-1:0] r;
      unique case (1'b1)
         (cur < tgt): r = cur + STEP_W'(1);
         (cur > tgt): r = cur - STEP_W'(1);
         default:     r = cur;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Configuration bus of the fade sequencer.
// Tick rate, dwell length and palette write port.
interface rgb_cfg_if #(
   parameter int WIDTH   = 8,
   parameter int ENTRIES = 4,
   parameter int DIV_W   = 16
);
   localparam int AW = $clog2(ENTRIES);

   logic [DIV_W-1:0]   cfg_tick_div;
   logic [7:0]         cfg_dwell;
   logic               cfg_we;
   logic [AW-1:0]      cfg_addr;
   logic [3*WIDTH-1:0] cfg_data;

   modport master (
      output cfg_tick_div, cfg_dwell, cfg_we, cfg_addr, cfg_data
   );

   modport slave (
      input cfg_tick_div, cfg_dwell, cfg_we, cfg_addr, cfg_data
   );

endinterface

// File: rtl/rgb_tick_gen.sv
// Free-running prescaler for the fade sequencer.
// Pulses tick when the count reaches cfg_tick_div.
module rgb_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DIV_W-1:0] cfg_tick_div,
   output logic             tick
);

   logic [DIV_W-1:0] count;

   assign tick = (count == cfg_tick_div);

   // Count up to the divider; a shrunk divider below count wraps to 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (count >= cfg_tick_div) begin
         count <= '0;
      end else begin
         count <= count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Level sequencer in front of the three PWM generators.
// Manual passthrough, palette auto-fade with dwell, encoder holdoff.
module rgb_fade_sequencer
   import rgb_seq_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int ENTRIES = 4,
   parameter  int DIV_W   = 16,
   localparam int AW      = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] manual_level0,
   input  logic [WIDTH-1:0] manual_level1,
   input  logic [WIDTH-1:0] manual_level2,
   input  logic             manual_active,
   rgb_cfg_if.slave         cfg,
   output logic [WIDTH-1:0] level0,
   output logic [WIDTH-1:0] level1,
   output logic [WIDTH-1:0] level2,
   output logic [1:0]       state,
   output logic [AW-1:0]    entry_idx,
   output logic             entry_done
);

   seq_state_t         st;
   logic [7:0]         cnt;
   logic               tick;
   logic               arrived;
   logic [WIDTH-1:0]   lvl [3];
   logic [WIDTH-1:0]   man [3];
   logic [WIDTH-1:0]   tgt [3];
   logic [WIDTH-1:0]   nxt [3];
   logic [3*WIDTH-1:0] pal [ENTRIES];

   function automatic logic [3*WIDTH-1:0] def_entry(input int unsigned i);
      logic [2:0] m;
      m = default_mask(i);
      return {{WIDTH{m[2]}}, {WIDTH{m[1]}}, {WIDTH{m[0]}}};
   endfunction

   assign man[0] = manual_level0;
   assign man[1] = manual_level1;
   assign man[2] = manual_level2;

   assign level0 = lvl[0];
   assign level1 = lvl[1];
   assign level2 = lvl[2];
   assign state  = st;

   rgb_tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick (
      .clk          (clk),
      .reset_n      (reset_n),
      .cfg_tick_div (cfg.cfg_tick_div),
      .tick         (tick)
   );

   // Palette storage; writes land the cycle after the strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pal[i] <= def_entry(i);
         end
      end else if (cfg.cfg_we) begin
         pal[cfg.cfg_addr] <= cfg.cfg_data;
      end
   end

   // Next fade step per channel and whether all channels land on target.
   always_comb begin
      arrived = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tgt[c] = pal[entry_idx][(2-c)*WIDTH +: WIDTH];
         nxt[c] = WIDTH'(step_toward(STEP_W'(lvl[c]), STEP_W'(tgt[c])));
         if (nxt[c] != tgt[c]) begin
            arrived = 1'b0;
         end
      end
   end

   // Sequencer FSM; enable low wins over everything else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st         <= MANUAL;
         cnt        <= '0;
         entry_idx  <= '0;
         entry_done <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            lvl[c] <= '0;
         end
      end else begin
         entry_done <= 1'b0;
         if (!enable) begin
            st <= MANUAL;
            if (st == MANUAL || st == HOLDOFF) begin
               for (int c = 0; c < 3; c++) begin
                  lvl[c] <= man[c];
               end
            end
         end else begin
            unique case (st)
               MANUAL: begin
                  for (int c = 0; c < 3; c++) begin
                     lvl[c] <= man[c];
                  end
                  st        <= FADE;
                  entry_idx <= '0;
               end
               FADE: begin
                  if (manual_active) begin
                     st  <= HOLDOFF;
                     cnt <= cfg.cfg_dwell;
                     for (int c = 0; c < 3; c++) begin
                        lvl[c] <= man[c];
                     end
                  end else if (tick) begin
                     for (int c = 0; c < 3; c++) begin
                        lvl[c] <= nxt[c];
                     end
                     if (arrived) begin
                        st  <= DWELL;
                        cnt <= cfg.cfg_dwell;
                     end
                  end
               end
               DWELL: begin
                  if (manual_active) begin
                     st  <= HOLDOFF;
                     cnt <= cfg.cfg_dwell;
                     for (int c = 0; c < 3; c++) begin
                        lvl[c] <= man[c];
                     end
                  end else if (tick) begin
                     if (cnt == 8'd0) begin
                        entry_idx  <= entry_idx + AW'(1);
                        entry_done <= 1'b1;
                        st         <= FADE;
                     end else begin
                        cnt <= cnt - 8'd1;
                     end
                  end
               end
               HOLDOFF: begin
                  for (int c = 0; c < 3; c++) begin
                     lvl[c] <= man[c];
                  end
                  if (manual_active) begin
                     cnt <= cfg.cfg_dwell;
                  end else if (tick) begin
                     if (cnt == 8'd0) begin
                        st <= FADE;
                     end else begin
                        cnt <= cnt - 8'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer.
// Manual vector table with scoreboard, then fade/holdoff/palette/reset sequences.
module tb_rgb_fade_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       manual_active;
   logic [7:0] ml0, ml1, ml2;
   logic [7:0] level0, level1, level2;
   logic [1:0] state;
   logic [1:0] entry_idx;
   logic       entry_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] in0, in1, in2;
      logic       act;
      logic [7:0] ex0, ex1, ex2;
      logic [1:0] exst;
   } vec_t;

   vec_t        vecs [5];
   logic [25:0] sb_q [$];

   rgb_cfg_if cfg_bus ();

   rgb_fade_sequencer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .manual_level0 (ml0),
      .manual_level1 (ml1),
      .manual_level2 (ml2),
      .manual_active (manual_active),
      .cfg           (cfg_bus),
      .level0        (level0),
      .level1        (level1),
      .level2        (level2),
      .state         (state),
      .entry_idx     (entry_idx),
      .entry_done    (entry_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] s, input logic [1:0] ix,
                             input int bound, input string name);
      int n;
      n = 0;
      while (!(state == s && entry_idx == ix) && n < bound) begin
         cyc();
         n++;
      end
      check(name, {state, entry_idx}, {s, ix});
   endtask

   task automatic wait_done(input int bound, input string name);
      int n;
      n = 0;
      while (entry_done !== 1'b1 && n < bound) begin
         cyc();
         n++;
      end
      check(name, entry_done, 1'b1);
   endtask

   initial begin
      logic [25:0] exp_v;
      logic [7:0]  prev;
      int          gap;
      int          n;

      vecs[0] = '{8'd12, 8'd34, 8'd56, 1'b0, 8'd12, 8'd34, 8'd56, 2'd0};
      vecs[1] = '{8'hFF, 8'h80, 8'h01, 1'b1, 8'hFF, 8'h80, 8'h01, 2'd0};
      vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0};
      vecs[3] = '{8'hAA, 8'h55, 8'h33, 1'b1, 8'hAA, 8'h55, 8'h33, 2'd0};
      vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0};

      reset_n               = 1'b0;
      enable                = 1'b0;
      manual_active         = 1'b0;
      ml0                   = 8'd0;
      ml1                   = 8'd0;
      ml2                   = 8'd0;
      cfg_bus.cfg_tick_div  = 16'd0;
      cfg_bus.cfg_dwell     = 8'd3;
      cfg_bus.cfg_we        = 1'b0;
      cfg_bus.cfg_addr      = 2'd0;
      cfg_bus.cfg_data      = 24'd0;

      cyc();
      cyc();
      check("rst_levels", {level0, level1, level2}, 24'h000000);
      check("rst_state", state, 2'd0);
      check("rst_idx", entry_idx, 2'd0);
      check("rst_done", entry_done, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         ml0           = vecs[i].in0;
         ml1           = vecs[i].in1;
         ml2           = vecs[i].in2;
         manual_active = vecs[i].act;
         sb_q.push_back({vecs[i].exst, vecs[i].ex0, vecs[i].ex1, vecs[i].ex2});
         cyc();
         exp_v = sb_q.pop_front();
         check("man_levels", {level0, level1, level2}, exp_v[23:0]);
         check("man_state", state, exp_v[25:24]);
      end
      manual_active = 1'b0;

      enable = 1'b1;
      cyc();
      check("fade_enter", {state, entry_idx}, {2'd1, 2'd0});
      check("fade_start", {level0, level1, level2}, 24'h000000);
      for (int k = 1; k <= 255; k++) begin
         cyc();
         check("fade_ramp", level0, k);
      end
      check("fade_arrive_st", state, 2'd2);
      check("fade_arrive_lv", {level0, level1, level2}, 24'hFF0000);
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("dwell_hold", {state, entry_done}, {2'd2, 1'b0});
      end
      cyc();
      check("dwell_done", entry_done, 1'b1);
      check("dwell_adv", {state, entry_idx}, {2'd1, 2'd1});
      cyc();
      check("fade1_step", {level0, level1, level2}, 24'hFE0100);
      check("fade1_done", entry_done, 1'b0);

      cfg_bus.cfg_tick_div = 16'd9;
      prev = level0;
      n = 0;
      while (level0 == prev && n < 30) begin
         cyc();
         n++;
      end
      check("rate_first", level0, 8'(prev - 8'd1));
      for (int r = 0; r < 3; r++) begin
         prev = level0;
         gap = 0;
         do begin
            cyc();
            gap++;
         end while (level0 == prev && gap < 30);
         check("rate_gap", gap, 10);
         check("rate_step", level0, 8'(prev - 8'd1));
      end
      cfg_bus.cfg_tick_div = 16'd0;
      cyc();

      cfg_bus.cfg_dwell = 8'd5;
      ml0 = 8'h80;
      ml1 = 8'h80;
      ml2 = 8'h80;
      manual_active = 1'b1;
      cyc();
      manual_active = 1'b0;
      check("hold_enter", state, 2'd3);
      check("hold_levels", {level0, level1, level2}, 24'h808080);
      cyc();
      cyc();
      manual_active = 1'b1;
      cyc();
      manual_active = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
      end
      check("hold_rearm", state, 2'd3);
      cyc();
      check("hold_exit", {state, entry_idx}, {2'd1, 2'd1});
      check("hold_exit_lv", {level0, level1, level2}, 24'h808080);
      cyc();
      check("hold_resume", {level0, level1, level2}, 24'h7F817F);

      cfg_bus.cfg_addr = 2'd3;
      cfg_bus.cfg_data = 24'h102030;
      cfg_bus.cfg_we   = 1'b1;
      cyc();
      cfg_bus.cfg_we    = 1'b0;
      cfg_bus.cfg_dwell = 8'd1;
      wait_state(2'd2, 2'd3, 2000, "pal_reach3");
      check("pal_levels", {level0, level1, level2}, 24'h102030);
      wait_done(20, "pal_wrap_done");
      check("pal_wrap", {state, entry_idx}, {2'd1, 2'd0});

      cfg_bus.cfg_dwell = 8'd200;
      wait_state(2'd2, 2'd0, 1000, "dwell0_reach");
      check("dwell0_lv", {level0, level1, level2}, 24'hFF0000);
      ml0 = 8'h11;
      ml1 = 8'h22;
      ml2 = 8'h33;
      enable = 1'b0;
      cyc();
      check("drop_state", state, 2'd0);
      check("drop_hold", {level0, level1, level2}, 24'hFF0000);
      cyc();
      check("drop_follow", {level0, level1, level2}, 24'h112233);

      ml0 = 8'h40;
      ml1 = 8'h40;
      ml2 = 8'h40;
      cfg_bus.cfg_dwell = 8'd0;
      enable = 1'b1;
      cyc();
      cyc();
      cyc();
      cyc();
      check("pre_rst_fade", state, 2'd1);
      check("pre_rst_lv", {level0, level1, level2}, 24'h433D3D);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_levels", {level0, level1, level2}, 24'h000000);
      check("arst_state", {state, entry_idx}, {2'd0, 2'd0});
      enable = 1'b0;
      ml0 = 8'h00;
      ml1 = 8'h00;
      ml2 = 8'h00;
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      enable = 1'b1;
      wait_state(2'd2, 2'd0, 400, "def_reach0");
      check("def_pal0", {level0, level1, level2}, 24'hFF0000);
      wait_state(2'd2, 2'd3, 3000, "def_reach3");
      check("def_pal3", {level0, level1, level2}, 24'hFFFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
